alien_sprite_renderer: RTL and testbench

- Per-scanline consumer of a 12x12 alien sprite ROM: addresses the ROM with a row index and latches the returned 12-bit row during horizontal blanking.
- Serialises that row into a 1-bit pixel stream aligned to the VGA beam position.
- Sits between the VGA sync generator (hpos/vpos) and the colour mux.
- One instance per alien sprite slot; the ROM is external, combinational, and attached via row_index/row_data.

---
 rtl/sprite_pkg.sv | 20 ++
 rtl/alien_sprite_renderer.sv | 111 +++++++++++
 tb/tb_alien_sprite_renderer.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/sprite_pkg.sv
// Shared constants and state encoding for the alien sprite renderers.
// Beam geometry follows the standard 640x480 VGA timing.
package sprite_pkg;

    localparam int DEF_SPRITE_W    = 12;
    localparam int DEF_SPRITE_H    = 12;
    localparam int DEF_SCALE_SHIFT = 1;
    localparam int DEF_H_FETCH     = 640;
    localparam int DEF_V_TOTAL     = 525;
    localparam int H_TOTAL         = 800;
    localparam int POS_W           = 10;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        ARMED,
        DRAW
    } state_t;

endpackage

// File: rtl/alien_sprite_renderer.sv
// Fetches one sprite row per scanline during hblank and serialises it into a
// 1-bit pixel stream, registered one cycle behind the sampled beam position.
module alien_sprite_renderer
    import sprite_pkg::*;
#(
    parameter int SPRITE_W    = DEF_SPRITE_W,
    parameter int SPRITE_H    = DEF_SPRITE_H,
    parameter int SCALE_SHIFT = DEF_SCALE_SHIFT,
    parameter int H_FETCH     = DEF_H_FETCH,
    parameter int V_TOTAL     = DEF_V_TOTAL
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [POS_W-1:0]    hpos,
    input  logic [POS_W-1:0]    vpos,
    input  logic                enable,
    input  logic [POS_W-1:0]    alien_x,
    input  logic [POS_W-1:0]    alien_y,
    output logic [3:0]          row_index,
    input  logic [SPRITE_W-1:0] row_data,
    output logic                pixel_on,
    output logic                busy
);

    localparam int HS    = SPRITE_H << SCALE_SHIFT;
    localparam int WS    = SPRITE_W << SCALE_SHIFT;
    localparam int COL_W = $clog2(WS + 1);
    localparam int IDX_W = $clog2(SPRITE_W);

    state_t              state, state_n;
    logic [3:0]          row_index_n;
    logic [SPRITE_W-1:0] line_buf, line_buf_n;
    logic [COL_W-1:0]    col, col_n, col_inc;
    logic                pixel_n;
    logic [POS_W:0]      next_line, line_off, top_edge;
    logic                at_fetch, fetch_hit;
    logic [IDX_W-1:0]    pix_idx;

    // Line arithmetic is one bit wider than the beam counters so alien_y+HS cannot wrap.
    assign top_edge  = {1'b0, alien_y};
    assign next_line = (vpos == POS_W'(V_TOTAL - 1)) ? '0 : {1'b0, vpos} + (POS_W+1)'(1);
    assign line_off  = next_line - top_edge;
    assign at_fetch  = (hpos == POS_W'(H_FETCH));
    assign fetch_hit = enable && at_fetch && (next_line >= top_edge) &&
                       (next_line < top_edge + (POS_W+1)'(HS));

    assign col_inc = col + COL_W'(1);
    assign pix_idx = IDX_W'(SPRITE_W - 1) - IDX_W'(col_inc >> SCALE_SHIFT);
    assign busy    = (state != IDLE);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_n     = state;
        row_index_n = row_index;
        line_buf_n  = line_buf;
        col_n       = col;
        pixel_n     = 1'b0;

        if (!enable) begin
            state_n = IDLE;
        end else if (at_fetch) begin
            // Start of hblank abandons any unfinished line before deciding on a new fetch.
            state_n = IDLE;
            if (fetch_hit) begin
                state_n     = FETCH;
                row_index_n = 4'(line_off >> SCALE_SHIFT);
            end
        end else begin
            unique case (state)
                IDLE: ;
                FETCH: begin
                    line_buf_n = row_data;
                    state_n    = ARMED;
                end
                ARMED: begin
                    if (hpos == alien_x && hpos < POS_W'(H_FETCH)) begin
                        state_n = DRAW;
                        col_n   = '0;
                        pixel_n = line_buf[SPRITE_W-1];
                    end
                end
                DRAW: begin
                    col_n = col_inc;
                    if (col_inc == COL_W'(WS))
                        state_n = IDLE;
                    else
                        pixel_n = line_buf[pix_idx];
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            row_index <= '0;
            line_buf  <= '0;
            col       <= '0;
            pixel_on  <= 1'b0;
        end else begin
            // NOTE: non-blocking updates keep every register sampling pre-edge values.
            state     <= state_n;
            row_index <= row_index_n;
            line_buf  <= line_buf_n;
            col       <= col_n;
            pixel_on  <= pixel_n;
        end
    end

endmodule

// File: tb/tb_alien_sprite_renderer.sv
// Self-checking bench: fetch-decision table plus scoreboarded full-scanline pixel streams.
module tb_alien_sprite_renderer;
    import sprite_pkg::*;

    localparam int WS = DEF_SPRITE_W << DEF_SCALE_SHIFT;
    localparam int HS = DEF_SPRITE_H << DEF_SCALE_SHIFT;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  hpos, vpos, alien_x, alien_y;
    logic        enable;
    logic [3:0]  row_index;
    logic [11:0] row_data;
    logic        pixel_on;
    logic        busy;

    logic [11:0] rom [16];
    assign row_data = rom[row_index];

    alien_sprite_renderer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .hpos      (hpos),
        .vpos      (vpos),
        .enable    (enable),
        .alien_x   (alien_x),
        .alien_y   (alien_y),
        .row_index (row_index),
        .row_data  (row_data),
        .pixel_on  (pixel_on),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int   v;
        int   h;
        logic pix;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        int v;
        int ay;
        bit en;
        bit exp_busy;
        int exp_row;
    } fv_t;
    fv_t fv[12];

    int ax, ay;
    bit drawable, pend;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic int next_line(input int v);
        return (v == DEF_V_TOTAL - 1) ? 0 : v + 1;
    endfunction

    // Geometric reference: which screen pixels belong to the sprite on this line.
    function automatic logic model_pix(input int v, input int h, input bit en);
        int c, row;
        if (!drawable || !en || h >= DEF_H_FETCH || h < ax || h >= ax + WS) return 1'b0;
        c   = h - ax;
        row = (v - ay) >> DEF_SCALE_SHIFT;
        return rom[row][DEF_SPRITE_W - 1 - (c >> DEF_SCALE_SHIFT)];
    endfunction

    task automatic run_line(input int v, input int h0, input int h1, input int drop_h);
        sb_t e;
        bit  en;
        for (int h = h0; h <= h1; h++) begin
            en      = (h < drop_h);
            hpos    = 10'(h);
            vpos    = 10'(v);
            enable  = en;
            alien_x = 10'(ax);
            alien_y = 10'(ay);
            if (h == DEF_H_FETCH)
                pend = en && (next_line(v) >= ay) && (next_line(v) < ay + HS);
            e.v = v; e.h = h; e.pix = model_pix(v, h, en);
            sb_q.push_back(e);
            @(posedge clk); #1;
            e = sb_q.pop_front();
            check($sformatf("pix v=%0d h=%0d", e.v, e.h), {31'd0, pixel_on}, {31'd0, e.pix});
            if (h == H_TOTAL - 1) drawable = pend;
        end
    endtask

    task automatic do_reset();
        #1 rst_n = 1'b0;
        drawable = 1'b0;
        pend     = 1'b0;
        sb_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n   = 1'b0;
        hpos    = '0;
        vpos    = '0;
        enable  = 1'b0;
        alien_x = '0;
        alien_y = '0;
        for (int i = 0; i < 16; i++) rom[i] = 12'(i * 273 + 5);
        drawable = 1'b0;
        pend     = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset pixel_on", {31'd0, pixel_on}, 32'd0);
        check("reset row_index", {28'd0, row_index}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;

        // Fetch decisions at H_FETCH: {vpos, alien_y, enable, busy after, row_index after}.
        fv[0]  = '{99,  100, 1'b1, 1'b1, 0};
        fv[1]  = '{101, 100, 1'b1, 1'b1, 1};
        fv[2]  = '{123, 100, 1'b1, 1'b0, 1};
        fv[3]  = '{122, 100, 1'b1, 1'b1, 11};
        fv[4]  = '{98,  100, 1'b1, 1'b0, 11};
        fv[5]  = '{100, 100, 1'b1, 1'b1, 0};
        fv[6]  = '{110, 100, 1'b1, 1'b1, 5};
        fv[7]  = '{110, 100, 1'b0, 1'b0, 5};
        fv[8]  = '{523, 0,   1'b1, 1'b0, 5};
        fv[9]  = '{524, 0,   1'b1, 1'b1, 0};
        fv[10] = '{522, 500, 1'b1, 1'b1, 11};
        fv[11] = '{524, 500, 1'b1, 1'b0, 11};
        alien_x = 10'd200;
        for (int i = 0; i < 12; i++) begin
            alien_y = 10'(fv[i].ay);
            for (int h = 638; h <= 641; h++) begin
                hpos   = 10'(h);
                vpos   = 10'(fv[i].v);
                enable = fv[i].en;
                @(posedge clk); #1;
                if (h == 640) begin
                    check($sformatf("fetch busy v=%0d", fv[i].v), {31'd0, busy}, {31'd0, fv[i].exp_busy});
                    check($sformatf("fetch row v=%0d", fv[i].v), {28'd0, row_index}, 32'(fv[i].exp_row));
                end else if (h == 641) begin
                    check($sformatf("armed busy v=%0d", fv[i].v), {31'd0, busy}, {31'd0, fv[i].exp_busy});
                    check($sformatf("hblank pixel v=%0d", fv[i].v), {31'd0, pixel_on}, 32'd0);
                end
            end
        end

        // Row 0 and row 1 drawn at 2x scale.
        do_reset();
        rom[0] = 12'b000011100000;
        rom[1] = 12'b100000000001;
        ax = 200; ay = 100;
        for (int v = 99; v <= 103; v++) run_line(v, 0, H_TOTAL - 1, H_TOTAL);

        // Vertical wrap: sprite at the top, fetched on the last line of the frame.
        do_reset();
        ax = 200; ay = 0;
        run_line(523, 0, H_TOTAL - 1, H_TOTAL);
        run_line(524, 0, H_TOTAL - 1, H_TOTAL);
        run_line(0,   0, H_TOTAL - 1, H_TOTAL);
        run_line(1,   0, H_TOTAL - 1, H_TOTAL);

        // Enable drops mid-draw; the following line must stay dark.
        do_reset();
        ax = 200; ay = 100;
        run_line(99,  0, H_TOTAL - 1, H_TOTAL);
        run_line(100, 0, H_TOTAL - 1, 205);
        run_line(101, 0, H_TOTAL - 1, H_TOTAL);
        run_line(102, 0, H_TOTAL - 1, H_TOTAL);

        // Horizontal clip at hblank, then a sprite placed entirely in hblank.
        do_reset();
        rom[0] = 12'hFFF;
        ax = 630; ay = 100;
        run_line(99,  0, H_TOTAL - 1, H_TOTAL);
        run_line(100, 0, H_TOTAL - 1, H_TOTAL);
        run_line(101, 0, H_TOTAL - 1, H_TOTAL);
        ax = 700;
        run_line(102, 0, H_TOTAL - 1, H_TOTAL);
        run_line(103, 0, H_TOTAL - 1, H_TOTAL);

        // Asynchronous reset in the middle of a drawn row.
        do_reset();
        rom[1] = 12'hFFF;
        ax = 200; ay = 98;
        run_line(99,  0, H_TOTAL - 1, H_TOTAL);
        run_line(100, 0, 209, H_TOTAL);
        check("pre-reset pixel_on", {31'd0, pixel_on}, 32'd1);
        check("pre-reset row_index", {28'd0, row_index}, 32'd1);
        check("pre-reset busy", {31'd0, busy}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("async reset pixel_on", {31'd0, pixel_on}, 32'd0);
        check("async reset row_index", {28'd0, row_index}, 32'd0);
        check("async reset busy", {31'd0, busy}, 32'd0);
        #1 rst_n = 1'b1;
        drawable = 1'b0;
        run_line(100, 210, H_TOTAL - 1, H_TOTAL);
        run_line(101, 0, H_TOTAL - 1, H_TOTAL);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
